// File: rtl/hazard_scoreboard_if.sv
// ID-stage bundle for hazard_scoreboard: issue record and source reads in,
// stall/bubble/forward decisions and status out.
interface hazard_scoreboard_if #(
   parameter int unsigned CNTW = 16
);
   logic            issue_valid;
   logic            issue_regwrite;
   logic            issue_load;
   logic [4:0]      issue_dst;
   logic [4:0]      read1;
   logic [4:0]      read2;
   logic            read1_used;
   logic            read2_used;
   logic            stall;
   logic            bubble;
   logic [1:0]      fwd_a;
   logic [1:0]      fwd_b;
   logic [1:0]      inflight;
   logic [CNTW-1:0] stall_count;

   modport master (
      output issue_valid, issue_regwrite, issue_load, issue_dst,
      output read1, read2, read1_used, read2_used,
      input  stall, bubble, fwd_a, fwd_b, inflight, stall_count
   );

   modport slave (
      input  issue_valid, issue_regwrite, issue_load, issue_dst,
      input  read1, read2, read1_used, read2_used,
      output stall, bubble, fwd_a, fwd_b, inflight, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks register writes through EX/MEM/WB and issues stall/bubble/forward controls to ID.
// Define HAZARD_SCOREBOARD_FWD_EN for forwarding mode; default build is interlock-only.
module hazard_scoreboard #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned CNTW  = 16
) (
   input logic                clk,
   input logic                reset_n,
   hazard_scoreboard_if.slave bus
);
   typedef struct packed {
      logic       valid;
      logic       load;
      logic [4:0] dst;
   } entry_t;

   entry_t [DEPTH-1:0] entry_q, entry_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic [DEPTH-1:0]   match_a, match_b;
   logic [1:0]         sel_a, sel_b;
   logic [1:0]         pop;
   logic               hazard;
   logic               stall;
   logic               unused_bits;

   always_comb begin
      match_a = '0;
      match_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_a[i] = entry_q[i].valid && (entry_q[i].dst == bus.read1) &&
                      bus.read1_used && (bus.read1 != 5'd0);
         match_b[i] = entry_q[i].valid && (entry_q[i].dst == bus.read2) &&
                      bus.read2_used && (bus.read2 != 5'd0);
      end
   end

`ifdef HAZARD_SCOREBOARD_FWD_EN
   // Walk oldest to youngest so the lowest matching stage is what remains.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (match_a[i]) sel_a = 2'(i + 1);
         if (match_b[i]) sel_b = 2'(i + 1);
      end
   end

   assign hazard      = entry_q[0].load && (match_a[0] || match_b[0]);
   assign unused_bits = entry_q[DEPTH-1].load;
`else
   assign sel_a       = '0;
   assign sel_b       = '0;
   // The WB stage writes through the register file, so it never interlocks.
   assign hazard      = (|match_a[DEPTH-2:0]) || (|match_b[DEPTH-2:0]);
   assign unused_bits = ^{entry_q[DEPTH-1].load, match_a[DEPTH-1], match_b[DEPTH-1]};
`endif

   assign stall = reset_n && hazard;

   always_comb begin
      pop = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pop = pop + 2'(entry_q[i].valid);
      end
   end

   always_comb begin
      bus.stall       = stall;
      bus.bubble      = stall;
      bus.fwd_a       = reset_n ? sel_a : 2'd0;
      bus.fwd_b       = reset_n ? sel_b : 2'd0;
      bus.inflight    = reset_n ? pop : 2'd0;
      bus.stall_count = cnt_q;
   end

   always_comb begin
      entry_d = '0;
      if (!stall) begin
         entry_d[0].valid = bus.issue_valid && bus.issue_regwrite && (bus.issue_dst != 5'd0);
         entry_d[0].load  = bus.issue_load;
         entry_d[0].dst   = bus.issue_dst;
      end
      for (int i = 1; i < DEPTH; i++) begin
         entry_d[i] = entry_q[i-1];
      end
      cnt_d = cnt_q;
      if (stall && !(&cnt_q)) cnt_d = cnt_q + CNTW'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         entry_q <= '0;
         cnt_q   <= '0;
      end else begin
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a write-history model;
// runs a CNTW=16 and a CNTW=4 instance side by side on identical stimulus.
module tb_hazard_scoreboard;
   localparam int DEPTH = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic iv = 1'b0, rw = 1'b0, ld = 1'b0, u1 = 1'b0, u2 = 1'b0;
   logic [4:0] dst = '0, r1 = '0, r2 = '0;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.CNTW(16)) bus16 ();
   hazard_scoreboard_if #(.CNTW(4))  bus4 ();

   always_comb begin
      bus16.issue_valid = iv;  bus16.issue_regwrite = rw;  bus16.issue_load = ld;
      bus16.issue_dst   = dst; bus16.read1 = r1; bus16.read2 = r2;
      bus16.read1_used  = u1;  bus16.read2_used = u2;
      bus4.issue_valid  = iv;  bus4.issue_regwrite = rw;   bus4.issue_load = ld;
      bus4.issue_dst    = dst; bus4.read1 = r1;  bus4.read2 = r2;
      bus4.read1_used   = u1;  bus4.read2_used = u2;
   end

   hazard_scoreboard #(.DEPTH(DEPTH), .CNTW(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));
   hazard_scoreboard #(.DEPTH(DEPTH), .CNTW(4))  dut4  (.clk(clk), .reset_n(reset_n), .bus(bus4));

   // Model: what each stage holds, i.e. the write accepted k edges ago, plus total stalls.
   bit m_valid[DEPTH];
   bit m_load[DEPTH];
   int m_dst[DEPTH];
   int m_stalls;
   int n_vec, n_bad;

   function automatic int youngest(int r, bit u);
      if (!u || r == 0) return -1;
      for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_dst[i] == r) return i;
      return -1;
   endfunction

   function automatic bit exp_stall();
      int ya, yb;
      if (reset_n !== 1'b1) return 1'b0;
      ya = youngest(int'(r1), u1);
      yb = youngest(int'(r2), u2);
`ifdef HAZARD_SCOREBOARD_FWD_EN
      return m_load[0] && (ya == 0 || yb == 0);
`else
      return (ya >= 0 && ya < DEPTH - 1) || (yb >= 0 && yb < DEPTH - 1);
`endif
   endfunction

   function automatic int exp_fwd(int r, bit u);
`ifdef HAZARD_SCOREBOARD_FWD_EN
      int y;
      if (reset_n !== 1'b1) return 0;
      y = youngest(r, u);
      return (y < 0) ? 0 : y + 1;
`else
      return 0;
`endif
   endfunction

   function automatic int exp_inflight();
      int n = 0;
      if (reset_n !== 1'b1) return 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
      return n;
   endfunction

   always @(posedge clk) begin
      bit s;
      s = exp_stall();
      if (reset_n !== 1'b1) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0; m_load[i] = 1'b0; m_dst[i] = 0;
         end
         m_stalls = 0;
      end else begin
         if (s) m_stalls++;
         for (int i = DEPTH - 1; i > 0; i--) begin
            m_valid[i] = m_valid[i-1]; m_load[i] = m_load[i-1]; m_dst[i] = m_dst[i-1];
         end
         m_valid[0] = !s && iv && rw && (dst != 5'd0);
         m_load[0]  = ld;
         m_dst[0]   = int'(dst);
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      bit s;
      s = exp_stall();
      chk("stall", 32'(bus16.stall), 32'(s));
      chk("bubble", 32'(bus16.bubble), 32'(s));
      chk("stall4", 32'(bus4.stall), 32'(s));
      chk("inflight", 32'(bus16.inflight), 32'(exp_inflight()));
      if (!s) begin
         chk("fwd_a", 32'(bus16.fwd_a), 32'(exp_fwd(int'(r1), u1)));
         chk("fwd_b", 32'(bus16.fwd_b), 32'(exp_fwd(int'(r2), u2)));
      end
      if (reset_n === 1'b1) begin
         chk("stall_count16", 32'(bus16.stall_count), 32'((m_stalls > 65535) ? 65535 : m_stalls));
         chk("stall_count4", 32'(bus4.stall_count), 32'((m_stalls > 15) ? 15 : m_stalls));
      end
   endtask

   task automatic apply(bit rn, bit v, bit w, bit l, int d, int a, bit ua, int b, bit ub);
      @(negedge clk);
      reset_n = rn; iv = v; rw = w; ld = l; dst = 5'(d);
      r1 = 5'(a); u1 = ua; r2 = 5'(b); u2 = ub;
      #1 compare_all();
   endtask

   task automatic do_reset();
      apply(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;

      // Reset state, including before any entry was ever cleared.
      do_reset();
      chk("rst_stall", 32'(bus16.stall), 32'd0);
      chk("rst_inflight", 32'(bus16.inflight), 32'd0);

      // Filtering: dst=0, regwrite=0, unused source.
      do_reset();
      apply(1, 1, 1, 0, 0, 0, 0, 0, 0);
      apply(1, 1, 0, 0, 4, 0, 1, 0, 0);
      chk("flt_r0_stall", 32'(bus16.stall), 32'd0);
      chk("flt_r0_infl", 32'(bus16.inflight), 32'd0);
      apply(1, 1, 1, 0, 8, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 8, 0, 4, 1);
      chk("flt_unused_stall", 32'(bus16.stall), 32'd0);
      chk("flt_unused_fwd_a", 32'(bus16.fwd_a), 32'd0);
      chk("flt_norw_fwd_b", 32'(bus16.fwd_b), 32'd0);
      chk("flt_infl", 32'(bus16.inflight), 32'd1);

`ifdef HAZARD_SCOREBOARD_FWD_EN
      // Load-use: one stall, then forward from MEM.
      do_reset();
      apply(1, 1, 1, 1, 5, 0, 0, 0, 0);
      apply(1, 1, 1, 0, 6, 5, 1, 0, 0);
      chk("lu_stall", 32'(bus16.stall), 32'd1);
      chk("lu_bubble", 32'(bus16.bubble), 32'd1);
      apply(1, 1, 1, 0, 6, 5, 1, 0, 0);
      chk("lu_stall2", 32'(bus16.stall), 32'd0);
      chk("lu_fwd_a", 32'(bus16.fwd_a), 32'd2);
      chk("lu_count", 32'(bus16.stall_count), 32'd1);
      // ALU-use: EX then MEM forwarding.
      do_reset();
      apply(1, 1, 1, 0, 7, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 7, 1);
      chk("alu_stall", 32'(bus16.stall), 32'd0);
      chk("alu_fwd_b1", 32'(bus16.fwd_b), 32'd1);
      apply(1, 0, 0, 0, 0, 0, 0, 7, 1);
      chk("alu_fwd_b2", 32'(bus16.fwd_b), 32'd2);
      // Youngest of two writers to r3 wins.
      do_reset();
      apply(1, 1, 1, 0, 3, 0, 0, 0, 0);
      apply(1, 1, 1, 0, 3, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 3, 1, 0, 0);
      chk("young_fwd_a", 32'(bus16.fwd_a), 32'd1);
`else
      // Interlock: two stall cycles until producer reaches WB.
      do_reset();
      apply(1, 1, 1, 0, 9, 0, 0, 0, 0);
      apply(1, 1, 1, 0, 10, 9, 1, 0, 0);
      chk("il_stall1", 32'(bus16.stall), 32'd1);
      chk("il_fwd_a1", 32'(bus16.fwd_a), 32'd0);
      apply(1, 1, 1, 0, 10, 9, 1, 0, 0);
      chk("il_stall2", 32'(bus16.stall), 32'd1);
      apply(1, 1, 1, 0, 10, 9, 1, 0, 0);
      chk("il_stall3", 32'(bus16.stall), 32'd0);
      chk("il_fwd_a3", 32'(bus16.fwd_a), 32'd0);
      chk("il_count", 32'(bus16.stall_count), 32'd2);
      do_reset();
      apply(1, 1, 1, 0, 3, 0, 0, 0, 0);
      apply(1, 1, 1, 0, 3, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 3, 1, 0, 0);
      chk("young_stall", 32'(bus16.stall), 32'd1);
`endif

      // Mid-operation reset with three valid entries and a pending load-use.
      do_reset();
      apply(1, 1, 1, 1, 1, 0, 0, 0, 0);
      apply(1, 1, 1, 0, 2, 0, 0, 0, 0);
      apply(1, 1, 1, 1, 5, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_infl", 32'(bus16.inflight), 32'd3);
      apply(0, 0, 0, 0, 0, 5, 1, 0, 0);
      chk("in_rst_stall", 32'(bus16.stall), 32'd0);
      apply(1, 0, 0, 0, 0, 5, 1, 0, 0);
      chk("post_rst_stall", 32'(bus16.stall), 32'd0);
      chk("post_rst_infl", 32'(bus16.inflight), 32'd0);
      chk("post_rst_cnt", 32'(bus16.stall_count), 32'd0);

      // Saturation of the narrow counter under a persistent hazard stream.
      do_reset();
      repeat (40) apply(1, 1, 1, 1, 10, 10, 1, 0, 0);
      chk("sat4", 32'(bus4.stall_count), 32'd15);
      repeat (10) apply(1, 1, 1, 1, 10, 10, 1, 0, 0);
      chk("sat4_hold", 32'(bus4.stall_count), 32'd15);

      // Random traffic; a stalled issue is re-presented unchanged.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         bit hold;
         hold = exp_stall();
         if (hold && $urandom_range(0, 199) != 0) begin
            apply(1, iv, rw, ld, int'(dst), int'(r1), u1, int'(r2), u2);
         end else begin
            apply($urandom_range(0, 99) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
                  1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
